// File: rtl/fibo_fsm_gen.sv
// Controller for the register-file/ALU Fibonacci datapath: counts iterations
// internally, picks Fibonacci/Lucas seeds and keeps a sticky overflow flag.
// Optional macro FIBO_OVF_STOP_EN: stop the run at the first ALU carry.
module fibo_fsm_gen #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2,
    parameter int OPC_W  = 3,
    parameter int CNT_W  = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              ABORT,
    input  logic [CNT_W-1:0]  N,
    input  logic              MODE,
    input  logic              CARRY_FLAG,
    output logic [ADDR_W-1:0] wrt_addr,
    output logic              wrt_en,
    output logic              load_data,
    output logic [DATA_W-1:0] seed_data,
    output logic [ADDR_W-1:0] rd_addr1,
    output logic [ADDR_W-1:0] rd_addr2,
    output logic [OPC_W-1:0]  alu_opcode,
    output logic              BUSY,
    output logic              DONE,
    output logic              OVF,
    output logic [2:0]        state_dbg
);

    // Handshake: START is a request taken only in S_IDLE; BUSY covers
    // S_LOAD_A..S_MOV_B; DONE pulses for the single S_FIN cycle; ABORT
    // returns any non-idle state to S_IDLE without DONE.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_CHECK  = 3'd3,
        S_ADD    = 3'd4,
        S_MOV_A  = 3'd5,
        S_MOV_B  = 3'd6,
        S_FIN    = 3'd7
    } state_t;

    localparam logic [OPC_W-1:0]  OPC_PASS = '0;
    localparam logic [OPC_W-1:0]  OPC_ADD  = OPC_W'(1);
    localparam logic [ADDR_W-1:0] REG_A    = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] REG_B    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] REG_T    = ADDR_W'(2);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               mode_lat, mode_nxt;
    logic               ovf_nxt;

    logic [ADDR_W-1:0]  wrt_addr_d, rd_addr1_d, rd_addr2_d;
    logic               wrt_en_d, load_data_d, busy_d, done_d;
    logic [DATA_W-1:0]  seed_d;
    logic [OPC_W-1:0]   opc_d;

    assign state_dbg = state;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mode_nxt  = mode_lat;
        ovf_nxt   = OVF;
        if (ABORT && state != S_IDLE) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        state_nxt = S_LOAD_A;
                        cnt_nxt   = N;
                        mode_nxt  = MODE;
                        ovf_nxt   = 1'b0;
                    end
                end
                S_LOAD_A: state_nxt = S_LOAD_B;
                S_LOAD_B: state_nxt = S_CHECK;
                S_CHECK:  state_nxt = (cnt == '0) ? S_FIN : S_ADD;
                S_ADD: begin
                    if (CARRY_FLAG) ovf_nxt = 1'b1;
`ifdef FIBO_OVF_STOP_EN
                    state_nxt = CARRY_FLAG ? S_FIN : S_MOV_A;
`else
                    state_nxt = S_MOV_A;
`endif
                end
                S_MOV_A: state_nxt = S_MOV_B;
                S_MOV_B: begin
                    cnt_nxt   = cnt - CNT_W'(1);
                    state_nxt = (cnt == CNT_W'(1)) ? S_FIN : S_ADD;
                end
                S_FIN:   state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they are registered yet
    // still line up with the state they belong to.
    always_comb begin
        wrt_addr_d  = '0;
        wrt_en_d    = 1'b0;
        load_data_d = 1'b0;
        seed_d      = '0;
        rd_addr1_d  = '0;
        rd_addr2_d  = '0;
        opc_d       = OPC_PASS;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        case (state_nxt)
            S_LOAD_A: begin
                wrt_en_d    = 1'b1;
                load_data_d = 1'b1;
                wrt_addr_d  = REG_A;
                seed_d      = mode_nxt ? DATA_W'(2) : '0;
                busy_d      = 1'b1;
            end
            S_LOAD_B: begin
                wrt_en_d    = 1'b1;
                load_data_d = 1'b1;
                wrt_addr_d  = REG_B;
                seed_d      = DATA_W'(1);
                busy_d      = 1'b1;
            end
            S_CHECK: busy_d = 1'b1;
            S_ADD: begin
                rd_addr1_d = REG_A;
                rd_addr2_d = REG_B;
                opc_d      = OPC_ADD;
                wrt_addr_d = REG_T;
                wrt_en_d   = 1'b1;
                busy_d     = 1'b1;
            end
            S_MOV_A: begin
                rd_addr1_d = REG_B;
                wrt_addr_d = REG_A;
                wrt_en_d   = 1'b1;
                busy_d     = 1'b1;
            end
            S_MOV_B: begin
                rd_addr1_d = REG_T;
                wrt_addr_d = REG_B;
                wrt_en_d   = 1'b1;
                busy_d     = 1'b1;
            end
            S_FIN:   done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= S_IDLE;
            cnt        <= '0;
            mode_lat   <= 1'b0;
            OVF        <= 1'b0;
            wrt_addr   <= '0;
            wrt_en     <= 1'b0;
            load_data  <= 1'b0;
            seed_data  <= '0;
            rd_addr1   <= '0;
            rd_addr2   <= '0;
            alu_opcode <= '0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            mode_lat   <= mode_nxt;
            OVF        <= ovf_nxt;
            wrt_addr   <= wrt_addr_d;
            wrt_en     <= wrt_en_d;
            load_data  <= load_data_d;
            seed_data  <= seed_d;
            rd_addr1   <= rd_addr1_d;
            rd_addr2   <= rd_addr2_d;
            alu_opcode <= opc_d;
            BUSY       <= busy_d;
            DONE       <= done_d;
        end
    end

endmodule

// File: doc/fibo_fsm_gen.md
Name: fibo_fsm_gen

Overview:
Parametrised controller for the register-file/ALU Fibonacci datapath. It computes term N of a Fibonacci-type sequence using an internal iteration counter, so it does not depend on an ALU zero flag. It selects Fibonacci or Lucas seeds and tracks ALU carry as a sticky overflow. It adds ABORT and a BUSY/DONE handshake.

Parameters:
DATA_W, 8, datapath word width (width of seed_data)
ADDR_W, 2, register-file address width (must be >=2)
OPC_W, 3, ALU opcode width
CNT_W, 8, width of N and of the internal iteration counter

Ports:
CLK  input  1  clock, rising edge
RST  input  1  synchronous active-low reset
START  input  1  start request; sampled only in IDLE
ABORT  input  1  cancel the current run
N  input  CNT_W  term index; latched on START accept
MODE  input  1  0 = Fibonacci seeds (0,1), 1 = Lucas seeds (2,1); latched on START accept
CARRY_FLAG  input  1  ALU carry-out for the current operation
wrt_addr  output  ADDR_W  register-file write address
wrt_en  output  1  register-file write enable
load_data  output  1  1 = write seed_data, 0 = write ALU result
seed_data  output  DATA_W  seed value
rd_addr1  output  ADDR_W  ALU operand A address
rd_addr2  output  ADDR_W  ALU operand B address
alu_opcode  output  OPC_W  0 = PASS A, 1 = ADD A+B
BUSY  output  1  run in progress
DONE  output  1  one-cycle completion pulse
OVF  output  1  sticky overflow for the current or last run

Behaviour:
- Reset
  - Reset applies when RST==0 at a CLK edge and dominates START and ABORT.
  - Reset puts the FSM in IDLE and clears the counter, OVF, latched N and latched MODE.
  - A reset mid-run abandons the run with no DONE.
- Register map: R0 = a (result), R1 = b, R2 = temp.
- Output decoding
  - All control outputs are decoded from the state register (Moore).
  - Outside the active states listed below, every control output is 0.
- States and transitions
  - IDLE: all outputs 0. START==1 -> latch N into cnt, latch MODE, clear OVF, go to LOAD_A.
  - LOAD_A: wrt_en=1, load_data=1, wrt_addr=0, seed_data = MODE?2:0 -> LOAD_B.
  - LOAD_B: wrt_en=1, load_data=1, wrt_addr=1, seed_data=1 -> CHECK.
  - CHECK: no write. cnt==0 -> FIN, else -> ADD.
  - ADD: rd_addr1=0, rd_addr2=1, opcode ADD, wrt_addr=2, wrt_en=1. CARRY_FLAG==1 sets OVF -> MOV_A.
  - MOV_A: rd_addr1=1, opcode PASS, wrt_addr=0, wrt_en=1 -> MOV_B.
  - MOV_B: rd_addr1=2, opcode PASS, wrt_addr=1, wrt_en=1, cnt decrements. cnt==1 -> FIN, else -> ADD.
  - FIN: DONE=1 for exactly one cycle -> IDLE.
- Handshake
  - BUSY=1 in LOAD_A through MOV_B; BUSY=0 in IDLE and FIN.
  - START is ignored outside IDLE, including FIN.
  - OVF holds after DONE until the next START is accepted.
- ABORT: in any state other than IDLE, ABORT==1 -> IDLE next cycle, no write beyond the current cycle's, no DONE; OVF retained.
- Latency (cycle 0 = edge sampling START)
  - N=0: FIN at cycle 4.
  - N>=1: FIN at cycle 4+3N.
  - Iteration k has its ADD at cycle 4+3(k-1).
- Arithmetic: R0 ends at term N mod 2^DATA_W. OVF reports any carry, including the carry from computing term N+1.

Optional Feature:
- Macro: FIBO_OVF_STOP_EN.
- Defined: in ADD, CARRY_FLAG==1 sets OVF and goes to FIN directly, skipping MOV_A/MOV_B. R0 holds the last non-overflowing term a.
- Undefined: the run continues with wrap-around to the full N iterations.

Test Plan:
- Reset (RST=0 two cycles) with START=1 -> FSM stays IDLE; all outputs 0; DONE, BUSY, OVF all 0.
- Fibonacci, N=5, MODE=0, bench datapath model -> R0=5, DONE pulse at cycle 19, BUSY high cycles 1-18, OVF=0.
- Lucas, N=4, MODE=1 -> LOAD_A seed_data=2; R0=7; DONE at cycle 16. Then N=0 -> R0=2, DONE at cycle 4.
- Fibonacci, DATA_W=8, N=14, macro undefined -> OVF=1 after cycle 40 ADD; DONE at cycle 46; R0=121. Macro defined -> DONE at cycle 41, R0=144, OVF=1.
- N=5 run, ABORT=1 during the iteration-2 MOV_A (cycle 8) -> IDLE at cycle 9; BUSY=0; no DONE. START asserted during cycles 2-7 of that run is ignored (N not re-latched).
- RST=0 during ADD of a run -> IDLE next edge; OVF=0; no DONE. A following START with N=3 -> R0=2, DONE at cycle 13.
